alu_op_sequencer: RTL

//  Multi-cycle controller in front of the 8-bit 74181-style ALU (S[3:0], M, CN, A, B -> F, CO, FZ).

---
 rtl/alu_op_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Multi-cycle controller in front of an 8-bit 74181-style ALU. It takes an
//   opcode on START and one or two operands over a shared valid/ready bus. It
//   drives the ALU control and operand lines for one EXEC cycle. It then
//   captures the result and the C/Z/E flags and pulses DONE.
// Ports
//   CLK, RST             clock, asynchronous active-high reset
//   START, OP[3:0]       begin operation (sampled in IDLE), opcode
//   DIN[7:0], DIN_VALID  operand bus and its valid strobe
//   DIN_READY            operand accepted this cycle (LOAD_A / LOAD_B)
//   ALU_S/M/CN/A/B       registered ALU control and operand lines
//   ALU_F, ALU_CO, ALU_FZ  ALU result, carry-out, not-equal indication
//   RESULT, C/Z/E_FLAG   registered result and flags
//   BUSY, DONE           operation in flight / one-cycle completion pulse
module alu_op_sequencer (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic [3:0] OP,
   input  logic [7:0] DIN,
   input  logic       DIN_VALID,
   output logic       DIN_READY,
   output logic [3:0] ALU_S,
   output logic       ALU_M,
   output logic       ALU_CN,
   output logic [7:0] ALU_A,
   output logic [7:0] ALU_B,
   input  logic [7:0] ALU_F,
   input  logic       ALU_CO,
   input  logic       ALU_FZ,
   output logic [7:0] RESULT,
   output logic       C_FLAG,
   output logic       Z_FLAG,
   output logic       E_FLAG,
   output logic       BUSY,
   output logic       DONE
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_A,
      ST_LOAD_B,
      ST_EXEC,
      ST_WB
   } state_e;

   localparam logic [3:0] OP_CMP = 4'hC;
   localparam logic [3:0] OP_NOP = 4'hF;

   state_e     state_q, state_d;
   logic [3:0] op_q, op_d;
   logic       cin_q, cin_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [3:0] s_q, s_d;
   logic       m_q, m_d;
   logic       cn_q, cn_d;
   logic [7:0] result_q, result_d;
   logic       c_q, c_d;
   logic       z_q, z_d;
   logic       e_q, e_d;

   logic [3:0] dec_s;
   logic       dec_m;
   logic       dec_cn;
   logic       dec_unary;
   logic       dec_arith;
   logic       hs;

   // Opcode decode from the latched opcode; CN for ADC/SBB/RLC uses the
   // carry snapshot taken at START acceptance.
   always_comb begin
      dec_s     = '0;
      dec_m     = 1'b0;
      dec_cn    = 1'b0;
      dec_unary = 1'b0;
      dec_arith = 1'b0;
      unique case (op_q)
         4'h0: begin dec_s = 4'b1001;                 dec_arith = 1'b1; end
         4'h1: begin dec_s = 4'b1001; dec_cn = cin_q; dec_arith = 1'b1; end
         4'h2: begin dec_s = 4'b0110;                 dec_arith = 1'b1; end
         4'h3: begin dec_s = 4'b0110; dec_cn = cin_q; dec_arith = 1'b1; end
         4'h4: begin dec_s = 4'b1011; dec_m = 1'b1; end
         4'h5: begin dec_s = 4'b1110; dec_m = 1'b1; end
         4'h6: begin dec_s = 4'b0110; dec_m = 1'b1; end
         4'h7: begin dec_s = 4'b0000; dec_m = 1'b1; dec_unary = 1'b1; end
         4'h8: begin dec_s = 4'b0000; dec_cn = 1'b1; dec_unary = 1'b1; dec_arith = 1'b1; end
         4'h9: begin dec_s = 4'b1111; dec_cn = 1'b1; dec_unary = 1'b1; dec_arith = 1'b1; end
         4'hA: begin dec_s = 4'b1100;                 dec_unary = 1'b1; dec_arith = 1'b1; end
         4'hB: begin dec_s = 4'b1100; dec_cn = cin_q; dec_unary = 1'b1; dec_arith = 1'b1; end
         4'hC: begin dec_s = 4'b0110;                 dec_arith = 1'b1; end
         4'hD: begin dec_s = 4'b1010; dec_m = 1'b1; end
         4'hE: begin dec_s = 4'b0011; dec_m = 1'b1; dec_unary = 1'b1; end
         default: ;
      endcase
   end

   assign hs = DIN_VALID & DIN_READY;

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (START) state_d = (OP == OP_NOP) ? ST_WB : ST_LOAD_A;
         ST_LOAD_A: if (hs)    state_d = dec_unary ? ST_EXEC : ST_LOAD_B;
         ST_LOAD_B: if (hs)    state_d = ST_EXEC;
         ST_EXEC:              state_d = ST_WB;
         ST_WB:                state_d = ST_IDLE;
         default:              state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      DIN_READY = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
      BUSY      = (state_q != ST_IDLE);
      DONE      = (state_q == ST_WB);
   end

   // Datapath next-state. Results are captured on the EXEC->WB edge so that
   // RESULT and flags are already valid in the cycle DONE is high. NOP skips
   // EXEC, so it never reaches the capture.
   always_comb begin
      op_d     = op_q;
      cin_d    = cin_q;
      a_d      = a_q;
      b_d      = b_q;
      s_d      = s_q;
      m_d      = m_q;
      cn_d     = cn_q;
      result_d = result_q;
      c_d      = c_q;
      z_d      = z_q;
      e_d      = e_q;

      if (state_q == ST_IDLE && START) begin
         op_d  = OP;
         cin_d = c_q;
      end

      if (state_q == ST_LOAD_A && hs) begin
         a_d = DIN;
         if (dec_unary) b_d = '0;
      end

      if (state_q == ST_LOAD_B && hs) b_d = DIN;

      if (state_d == ST_EXEC && state_q != ST_EXEC) begin
         s_d  = dec_s;
         m_d  = dec_m;
         cn_d = dec_cn;
      end

      if (state_q == ST_EXEC) begin
         if (op_q != OP_CMP) result_d = ALU_F;
         c_d = dec_arith ? ALU_CO : 1'b0;
         z_d = (ALU_F == '0);
         e_d = ~ALU_FZ;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         op_q     <= '0;
         cin_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         s_q      <= '0;
         m_q      <= 1'b0;
         cn_q     <= 1'b0;
         result_q <= '0;
         c_q      <= 1'b0;
         z_q      <= 1'b0;
         e_q      <= 1'b0;
      end else begin
         op_q     <= op_d;
         cin_q    <= cin_d;
         a_q      <= a_d;
         b_q      <= b_d;
         s_q      <= s_d;
         m_q      <= m_d;
         cn_q     <= cn_d;
         result_q <= result_d;
         c_q      <= c_d;
         z_q      <= z_d;
         e_q      <= e_d;
      end
   end

   assign ALU_S  = s_q;
   assign ALU_M  = m_q;
   assign ALU_CN = cn_q;
   assign ALU_A  = a_q;
   assign ALU_B  = b_q;
   assign RESULT = result_q;
   assign C_FLAG = c_q;
   assign Z_FLAG = z_q;
   assign E_FLAG = e_q;

endmodule
